// File: rtl/cordic_pkg.sv
// Shared constants and float layout for the cosine accelerator datapath.
// Imported by the CORDIC core and by the fixed-to-float output stage.
package cordic_pkg;

  localparam int FP_BIAS   = 127;
  localparam int Q_FRAC    = 31;
  localparam int FP_MANT_W = 23;
  localparam int FP_EXP_W  = 8;

  // Biased exponent of a Q1.31 bit at position 0.
  localparam int EXP_OFS = FP_BIAS - Q_FRAC;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp32_t;

endpackage

// File: rtl/cordic_fix2float_if.sv
// Sample bus into and out of the fixed-to-float stage.
// Valid-qualified in both directions; no ready, stalls come from clk_en.
interface cordic_fix2float_if;

  logic        in_valid;
  logic [31:0] dataa;
  logic        out_valid;
  logic [31:0] result;

  modport master (output in_valid, output dataa, input out_valid, input result);
  modport slave  (input in_valid, input dataa, output out_valid, output result);

endinterface

// File: rtl/cordic_fix2float_lzd32.sv
// Combinational leading-one detector for a 32-bit word.
// Zero latency; pos is 0 when din is zero, nz flags a non-zero word.
module lzd32 (
  input  logic [31:0] din,
  output logic [4:0]  pos,
  output logic        nz
);

  always_comb begin
    pos = '0;
    for (int i = 0; i < 32; i++) begin
      if (din[i]) pos = 5'(i);
    end
  end

  assign nz = |din;

endmodule

// File: rtl/cordic_fix2float.sv
// Q1.31 to IEEE-754 single conversion, 3 enabled cycles of latency, 1 sample per cycle.
// No backpressure: clk_en low freezes every stage and valid bit.
module cordic_fix2float
  import cordic_pkg::*;
#(
  parameter bit ROUND_NEAREST = 1'b1
) (
  input  logic                     clock,
  input  logic                     aclr,
  input  logic                     clk_en,
  cordic_fix2float_if.slave        bus
);

  // S1: sign and magnitude
  logic        vld1_q, sign1_q, sign1_d;
  logic [31:0] mag1_q, mag1_d;

  // S2: leading-one position
  logic        vld2_q, sign2_q, nz2_q, nz2_d;
  logic [31:0] mag2_q;
  logic [4:0]  p2_q, p2_d;

  // S3: packed float
  logic        vld3_q;
  fp32_t       res_q, res_d;

  logic [30:0] n3;
  logic [22:0] m_trunc;
  logic        g3, s3, rnd_up;
  logic [23:0] m_sum;
  logic [7:0]  e3;

  assign sign1_d = bus.dataa[31];
  // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
  assign mag1_d  = sign1_d ? (~bus.dataa + 32'd1) : bus.dataa;

  lzd32 u_lzd (
    .din (mag1_q),
    .pos (p2_d),
    .nz  (nz2_d)
  );

  always_comb begin
    n3      = 31'(mag2_q << (5'd31 - p2_q));
    m_trunc = n3[30:8];
    g3      = n3[7];
    s3      = |n3[6:0];
    rnd_up  = ROUND_NEAREST && g3 && (s3 || m_trunc[0]);
    // A carry out of the mantissa leaves it at zero and bumps the exponent.
    m_sum   = {1'b0, m_trunc} + {23'd0, rnd_up};
    e3      = 8'(EXP_OFS) + {3'd0, p2_q} + {7'd0, m_sum[23]};
    res_d   = '0;
    if (nz2_q) begin
      res_d.sign = sign2_q;
      res_d.exp  = e3;
      res_d.mant = m_sum[22:0];
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      vld1_q  <= 1'b0;
      sign1_q <= 1'b0;
      mag1_q  <= '0;
      vld2_q  <= 1'b0;
      sign2_q <= 1'b0;
      mag2_q  <= '0;
      p2_q    <= '0;
      nz2_q   <= 1'b0;
      vld3_q  <= 1'b0;
      res_q   <= '0;
    end else if (clk_en) begin
      vld1_q  <= bus.in_valid;
      sign1_q <= sign1_d;
      mag1_q  <= mag1_d;
      vld2_q  <= vld1_q;
      sign2_q <= sign1_q;
      mag2_q  <= mag1_q;
      p2_q    <= p2_d;
      nz2_q   <= nz2_d;
      vld3_q  <= vld2_q;
      res_q   <= res_d;
    end
  end

  assign bus.out_valid = vld3_q;
  assign bus.result    = res_q;

endmodule

// File: doc/cordic_fix2float.md
# cordic_fix2float

Output stage of the cosine accelerator: converts the CORDIC core's 32-bit signed Q1.31 fixed-point result into IEEE-754 single precision. The block is a 3-stage pipeline with a valid bit and a global stall (`clk_en`), and accepts one sample per enabled cycle. It sits directly downstream of the CORDIC iteration core and drives the accelerator's 32-bit `result` to the host.

## Interface
- `ROUND_NEAREST`, default 1: 1 = round-to-nearest-even; 0 = truncate toward zero.
- `clock`  in  1  sole clock, rising edge.
- `aclr`  in  1  reset, asynchronous, active-high.
- `clk_en`  in  1  pipeline advance. Low freezes every register.
- `in_valid`  in  1  `dataa` holds a sample this cycle.
- `dataa`  in  32  Q1.31 two's complement. Value = signed(dataa)/2^31, range [-1, 1).
- `out_valid`  out  1  `result` holds a converted sample.
- `result`  out  32  IEEE-754 single-precision float.

## Operation
- **S1 (sign/abs):** register `sign = dataa[31]`, `mag = sign ? -dataa : dataa` as 32-bit unsigned. 0x80000000 yields `mag` = 0x80000000.
- **S2 (leading-one detect):** `p` = index of the most significant 1 in `mag` (0..31), plus `nz = |mag`. Register `sign`, `mag`, `p`, `nz`.
- **S3 (normalise/round/pack):**
  - `n = mag << (31-p)`.
  - Mantissa field `m = n[30:8]`, guard `g = n[7]`, sticky `s = |n[6:0]`.
  - Exponent `e = 96 + p` (8 bits).
  - With RNE: round up when `g & (s | m[0])`. If `m` overflows from all ones, `m = 0` and `e = e + 1`.
  - Pack `{sign, e, m}`.
- Zero input (`nz = 0`) → `result = 0x00000000` (positive zero); the sign is dropped.
- Denormals, inf and NaN are never produced. The smallest exponent is 96; the largest result magnitude is 1.0 (`e = 127`, from -1.0 or rounding carry).
- `out_valid` is `in_valid` delayed through the three stages. Data stages load regardless of valid; only the valid bits gate meaning.

## Timing
- Latency: 3 enabled cycles from `in_valid`/`dataa` sampled to `out_valid`/`result`.
- Throughput: 1 sample per enabled cycle. No backpressure beyond `clk_en`.
- `clk_en = 0`: all stage registers and valid bits hold. `result` and `out_valid` remain stable and are not re-issued as new samples.
- Reset values: all stage registers 0, `out_valid = 0`, `result = 0x00000000`.
- `aclr` asserted mid-stream clears all in-flight samples immediately, regardless of `clock`. The first valid output after release appears 3 enabled cycles after the first sampled `in_valid`.
- `aclr` dominates `clk_en`.
- `result` is a registered output with no combinational path from the inputs.

## Structure
- Shared package `cordic_pkg` holds:
  - `FP_BIAS = 127`, `Q_FRAC = 31`, `FP_MANT_W = 23`, `FP_EXP_W = 8`.
  - A packed float struct with fields sign, exp and mant.
- The CORDIC core imports the same package.
- One sub-module `lzd32`: combinational 32-bit leading-one detector with outputs `pos[4:0]` and `nz`, used in S2.
- Everything else stays inline.

## Test plan
- **Exact values:** reset, then one sample each, `clk_en = 1`. Required: 0x40000000 → 0x3F000000 (0.5); 0x80000000 → 0xBF800000 (-1.0); 0x00000000 → 0x00000000; 0x00000001 → 0x30000000; 0xFFFFFFFF → 0xB0000000. Each appears 3 cycles after input.
- **Rounding:**
  - 0x4DBA76D4 → 0x3F1B74EE (round up, sticky set).
  - 0x7FFFFFFF → 0x3F800000 (mantissa carry into exponent).
  - With `ROUND_NEAREST = 0`: 0x4DBA76D4 → 0x3F1B74ED and 0x7FFFFFFF → 0x3F7FFFFF.
- **Back-to-back streaming:** 100 random samples on consecutive cycles → outputs in order, one per cycle, bit-exact against a reference model using RNE, with no bubbles.
- **Stall:** stream samples, drop `clk_en` for 5 cycles mid-stream → `result` and `out_valid` frozen during the stall; the sequence resumes with no loss or duplication.
- **Reset mid-flight:** 3 samples in flight, pulse `aclr` between clock edges → `out_valid` and `result` go to 0 immediately. None of the flushed samples appear afterwards; a new sample emerges 3 cycles after it is issued.
- **Valid gaps:** alternating `in_valid` 1/0 → `out_valid` follows the same pattern delayed by 3 cycles.
